// File: rtl/memory_access.sv
// Pipeline MEM stage: data-memory loads/stores with sub-word lanes, address exceptions, MEM/WB register.
// Latency: 1 cycle, from inputs sampled at a rising edge to the registered outputs after that edge.
// Backpressure: none; a new instruction is accepted every cycle, and reset/flush squash the current one.
//
// Ports:
//   clk, reset (sync, active-high)
//   Inst, AO (byte address), rt (store data), exception_in/EPC_in/ExcCode_in/BD_in from EX, flush
//   Inst_out, AO_out, DR (extended load data), exception_out, EPC_out, ExcCode_out, BD_out to WB
//
// Build option MEMORY_ACCESS_SUBWORD_EN: when defined, lb/lbu/lh/lhu/sb/sh access memory.
// When undefined, those six opcodes raise RI (ExcCode 10) and do not touch memory.
module memory_access #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] AO,
  input  logic [31:0] rt,
  input  logic        exception_in,
  input  logic [31:0] EPC_in,
  input  logic [4:0]  ExcCode_in,
  input  logic        BD_in,
  input  logic        flush,
  output logic [31:0] Inst_out,
  output logic [31:0] AO_out,
  output logic [31:0] DR,
  output logic        exception_out,
  output logic [31:0] EPC_out,
  output logic [4:0]  ExcCode_out,
  output logic        BD_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // 33 bits so the byte-size limit cannot overflow even for a 4 GiB array.
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

`ifdef MEMORY_ACCESS_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;

  logic [31:0] mem [DEPTH_WORDS];

  logic          is_load, is_store, is_half, is_byte, is_signed;
  logic          is_mem, is_sub, ri, out_of_range, misaligned;
  logic          local_exc, exc;
  logic [4:0]    local_code;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rword;
  logic [7:0]    byte_val;
  logic [15:0]   half_val;
  logic [31:0]   load_data;
  logic [31:0]   dr_next;

  // Opcode decode
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_half   = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    unique case (Inst[31:26])
      OP_LW:   is_load = 1'b1;
      OP_LH:   begin is_load = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OP_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
      OP_LB:   begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OP_LBU:  begin is_load = 1'b1; is_byte = 1'b1; end
      OP_SW:   is_store = 1'b1;
      OP_SH:   begin is_store = 1'b1; is_half = 1'b1; end
      OP_SB:   begin is_store = 1'b1; is_byte = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;
  assign is_sub = is_half | is_byte;

  // Exceptions: RI dominates because the opcode is not a memory op in that build;
  // range and alignment both map to AdEL/AdES, so their relative order has no visible effect.
  assign ri           = is_sub & ~SUBWORD;
  assign out_of_range = ({1'b0, AO} >= LIMIT);
  assign misaligned   = (is_mem & ~is_sub & (AO[1:0] != 2'b00)) | (is_half & AO[0]);
  assign local_exc    = ri | (is_mem & (out_of_range | misaligned));
  assign local_code   = ri ? EXC_RI : (is_load ? EXC_ADEL : EXC_ADES);
  assign exc          = exception_in | local_exc;

  assign widx = AO[AW+1:2];
  assign lane = AO[1:0];
  assign we   = is_store & ~exc & ~flush & ~reset;

  // Store lanes: data is replicated across the word so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b0000;
    wdata = rt;
    if (is_byte) begin
      be    = 4'b0001 << lane;
      wdata = {4{rt[7:0]}};
    end else if (is_half) begin
      be    = AO[1] ? 4'b1100 : 4'b0011;
      wdata = {2{rt[15:0]}};
    end else begin
      be    = 4'b1111;
    end
  end

  // Load extraction
  assign rword = mem[widx];

  always_comb begin
    byte_val = rword[7:0];
    unique case (lane)
      2'd0: byte_val = rword[7:0];
      2'd1: byte_val = rword[15:8];
      2'd2: byte_val = rword[23:16];
      2'd3: byte_val = rword[31:24];
      default: ;
    endcase
  end

  assign half_val = AO[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    if (is_byte)
      load_data = {{24{is_signed & byte_val[7]}}, byte_val};
    else if (is_half)
      load_data = {{16{is_signed & half_val[15]}}, half_val};
  end

  // An excepting load never reaches writeback, so its data is zeroed rather than
  // exposing a read from an out-of-range or misaligned address.
  assign dr_next = (is_load & ~exc) ? load_data : 32'h0;

  // Data memory: cleared in one cycle by reset, byte-enabled writes otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // MEM/WB boundary register
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      Inst_out      <= 32'h0;
      AO_out        <= 32'h0;
      DR            <= 32'h0;
      exception_out <= 1'b0;
      EPC_out       <= 32'h0;
      ExcCode_out   <= 5'd0;
      BD_out        <= 1'b0;
    end else begin
      Inst_out      <= exc ? 32'h0 : Inst;
      AO_out        <= AO;
      DR            <= dr_next;
      exception_out <= exc;
      EPC_out       <= EPC_in;
      ExcCode_out   <= exception_in ? ExcCode_in : (local_exc ? local_code : 5'd0);
      BD_out        <= BD_in;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam int DEPTH = 4096;
  localparam int NBYTES = 4 * DEPTH;

`ifdef MEMORY_ACCESS_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, exception_in, BD_in;
  logic [31:0] Inst, AO, rt, EPC_in;
  logic [4:0]  ExcCode_in;
  logic [31:0] Inst_out, AO_out, DR, EPC_out;
  logic        exception_out, BD_out;
  logic [4:0]  ExcCode_out;

  int checks = 0;
  int errors = 0;

  memory_access #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .AO(AO), .rt(rt),
    .exception_in(exception_in), .EPC_in(EPC_in), .ExcCode_in(ExcCode_in),
    .BD_in(BD_in), .flush(flush),
    .Inst_out(Inst_out), .AO_out(AO_out), .DR(DR), .exception_out(exception_out),
    .EPC_out(EPC_out), .ExcCode_out(ExcCode_out), .BD_out(BD_out)
  );

  always #5 clk = ~clk;

  wire [134:0] act_v = {Inst_out, AO_out, DR, exception_out, EPC_out, ExcCode_out, BD_out};
  logic [134:0] exp_v;

  // Reference: byte-addressed memory, accesses described as runs of consecutive bytes.
  logic [7:0] ref_mem [NBYTES];

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'h0421234};
  endfunction

  task automatic model_step(input logic rst, input logic fl, input logic [31:0] inst,
                            input logic [31:0] ao, input logic [31:0] rtv, input logic exin,
                            input logic [31:0] epc, input logic [4:0] code, input logic bd,
                            output logic [134:0] e);
    int size;
    bit ld, st, sgn, loc;
    logic [4:0]  lcode;
    logic [31:0] dr;
    e = '0;
    if (rst) begin
      for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h0;
      return;
    end
    if (fl) return;
    size = 0; ld = 0; st = 0; sgn = 0;
    case (inst[31:26])
      6'h23: begin size = 4; ld = 1; end
      6'h21: begin size = 2; ld = 1; sgn = 1; end
      6'h25: begin size = 2; ld = 1; end
      6'h20: begin size = 1; ld = 1; sgn = 1; end
      6'h24: begin size = 1; ld = 1; end
      6'h2B: begin size = 4; st = 1; end
      6'h29: begin size = 2; st = 1; end
      6'h28: begin size = 1; st = 1; end
      default: ;
    endcase
    loc = 0; lcode = 5'd0;
    if ((size == 1 || size == 2) && !SUBWORD) begin
      loc = 1; lcode = 5'd10;
    end else if (size != 0 && (ao >= NBYTES || (ao % size) != 0)) begin
      loc = 1; lcode = ld ? 5'd4 : 5'd5;
    end
    dr = 32'h0;
    if (!exin && !loc) begin
      if (st)
        for (int k = 0; k < size; k++) ref_mem[ao + k] = rtv[8*k +: 8];
      if (ld) begin
        for (int k = 0; k < size; k++) dr[8*k +: 8] = ref_mem[ao + k];
        if (sgn && dr[8*size-1])
          for (int k = size; k < 4; k++) dr[8*k +: 8] = 8'hFF;
      end
    end
    e = {(exin || loc) ? 32'h0 : inst, ao, dr, exin || loc, epc, exin ? code : lcode, bd};
  endtask

  // Drive one instruction, advance the reference, and land 1 time unit after the edge.
  task automatic step(input logic rst, input logic fl, input logic [31:0] inst,
                      input logic [31:0] ao, input logic [31:0] rtv, input logic exin,
                      input logic [31:0] epc, input logic [4:0] code, input logic bd);
    reset = rst; flush = fl; Inst = inst; AO = ao; rt = rtv;
    exception_in = exin; EPC_in = epc; ExcCode_in = code; BD_in = bd;
    model_step(rst, fl, inst, ao, rtv, exin, epc, code, bd, exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [5:0] opc, input logic [31:0] ao, input logic [31:0] rtv);
    step(1'b0, 1'b0, mk(opc), ao, rtv, 1'b0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, mk(6'h2B), 32'h10, 32'h1234, 1'b1, 32'h55, 5'd3, 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (act_v !== 135'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", act_v);
    end
  endtask

  task automatic test_store_load;
    op(6'h2B, 32'h10, 32'h89ABCDEF);
    checks++;
    if (Inst_out !== mk(6'h2B) || exception_out !== 1'b0) begin
      errors++; $display("FAIL sw_pass got inst=%h exc=%b want inst=%h exc=0", Inst_out, exception_out, mk(6'h2B));
    end
    op(6'h23, 32'h10, 32'h0);
    checks++;
    if (DR !== 32'h89ABCDEF || Inst_out !== mk(6'h23)) begin
      errors++; $display("FAIL lw_after_sw got dr=%h inst=%h want dr=89abcdef inst=%h", DR, Inst_out, mk(6'h23));
    end
  endtask

  task automatic test_subword;
    logic [31:0] want_w, want_lb, want_lbu, want_lhu;
    want_w   = SUBWORD ? 32'h89ABF0EF : 32'h89ABCDEF;
    want_lb  = SUBWORD ? 32'hFFFFFFF0 : 32'h0;
    want_lbu = SUBWORD ? 32'h000000F0 : 32'h0;
    want_lhu = SUBWORD ? 32'h000089AB : 32'h0;
    op(6'h28, 32'h11, 32'h000000F0);
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL sb_outputs got %h want %h", act_v, exp_v);
    end
    op(6'h23, 32'h10, 32'h0);
    checks++;
    if (DR !== want_w) begin
      errors++; $display("FAIL sb_merge got %h want %h", DR, want_w);
    end
    op(6'h20, 32'h11, 32'h0);
    checks++;
    if (DR !== want_lb || exception_out !== !SUBWORD) begin
      errors++; $display("FAIL lb_sext got dr=%h exc=%b want dr=%h exc=%b", DR, exception_out, want_lb, !SUBWORD);
    end
    op(6'h24, 32'h11, 32'h0);
    checks++;
    if (DR !== want_lbu) begin
      errors++; $display("FAIL lbu_zext got %h want %h", DR, want_lbu);
    end
    op(6'h25, 32'h12, 32'h0);
    checks++;
    if (DR !== want_lhu || act_v !== exp_v) begin
      errors++; $display("FAIL lhu_zext got dr=%h vec=%h want dr=%h vec=%h", DR, act_v, want_lhu, exp_v);
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] old;
    op(6'h21, 32'h13, 32'h0);
    checks++;
    if (exception_out !== 1'b1 || ExcCode_out !== (SUBWORD ? 5'd4 : 5'd10) || Inst_out !== 32'h0) begin
      errors++; $display("FAIL lh_misaligned got exc=%b code=%0d inst=%h want exc=1 code=%0d inst=0",
                         exception_out, ExcCode_out, Inst_out, SUBWORD ? 4 : 10);
    end
    old = SUBWORD ? 32'h89ABF0EF : 32'h89ABCDEF;
    op(6'h2B, 32'h12, 32'h11111111);
    checks++;
    if (ExcCode_out !== 5'd5 || exception_out !== 1'b1 || Inst_out !== 32'h0) begin
      errors++; $display("FAIL sw_misaligned got code=%0d exc=%b inst=%h want code=5 exc=1 inst=0", ExcCode_out, exception_out, Inst_out);
    end
    op(6'h23, 32'h10, 32'h0);
    checks++;
    if (DR !== old) begin
      errors++; $display("FAIL sw_misaligned_nowrite got %h want %h", DR, old);
    end
  endtask

  task automatic test_upstream;
    step(1'b0, 1'b0, mk(6'h2B), 32'h20, 32'hDEADBEEF, 1'b1, 32'h3008, 5'd12, 1'b1);
    checks++;
    if (exception_out !== 1'b1 || ExcCode_out !== 5'd12 || EPC_out !== 32'h3008 || BD_out !== 1'b1 || Inst_out !== 32'h0) begin
      errors++; $display("FAIL upstream_fields got exc=%b code=%0d epc=%h bd=%b inst=%h want 1 12 00003008 1 0",
                         exception_out, ExcCode_out, EPC_out, BD_out, Inst_out);
    end
    // Upstream code wins over a local misalignment.
    step(1'b0, 1'b0, mk(6'h23), 32'h22, 32'h0, 1'b1, 32'h4000, 5'd12, 1'b0);
    checks++;
    if (ExcCode_out !== 5'd12) begin
      errors++; $display("FAIL upstream_over_local got %0d want 12", ExcCode_out);
    end
    op(6'h23, 32'h20, 32'h0);
    checks++;
    if (DR !== 32'h0) begin
      errors++; $display("FAIL upstream_nowrite got %h want 0", DR);
    end
  endtask

  task automatic test_flush_reset;
    step(1'b0, 1'b1, mk(6'h2B), 32'h30, 32'hCAFEF00D, 1'b1, 32'h99, 5'd7, 1'b1);
    checks++;
    if (act_v !== 135'h0) begin
      errors++; $display("FAIL flush_outputs got %h want 0", act_v);
    end
    op(6'h23, 32'h30, 32'h0);
    checks++;
    if (DR !== 32'h0 || Inst_out !== mk(6'h23)) begin
      errors++; $display("FAIL flush_nowrite got dr=%h inst=%h want dr=0 inst=%h", DR, Inst_out, mk(6'h23));
    end
    op(6'h2B, 32'h40, 32'h13572468);
    step(1'b1, 1'b0, mk(6'h2B), 32'h44, 32'h2468ACE0, 1'b0, 32'h0, 5'd0, 1'b0);
    checks++;
    if (act_v !== 135'h0) begin
      errors++; $display("FAIL reset_mid_outputs got %h want 0", act_v);
    end
    op(6'h23, 32'h10, 32'h0);
    checks++;
    if (DR !== 32'h0 || Inst_out !== mk(6'h23)) begin
      errors++; $display("FAIL reset_clears_mem got dr=%h inst=%h want dr=0 inst=%h", DR, Inst_out, mk(6'h23));
    end
  endtask

  task automatic test_boundary;
    op(6'h2B, 32'h3FFC, 32'hA5A5C3C3);
    checks++;
    if (exception_out !== 1'b0 || Inst_out !== mk(6'h2B)) begin
      errors++; $display("FAIL sw_top_legal got exc=%b inst=%h want exc=0 inst=%h", exception_out, Inst_out, mk(6'h2B));
    end
    op(6'h23, 32'h3FFC, 32'h0);
    checks++;
    if (DR !== 32'hA5A5C3C3) begin
      errors++; $display("FAIL lw_top got %h want a5a5c3c3", DR);
    end
    op(6'h2B, 32'h4000, 32'h77777777);
    checks++;
    if (exception_out !== 1'b1 || ExcCode_out !== 5'd5) begin
      errors++; $display("FAIL sw_oor got exc=%b code=%0d want exc=1 code=5", exception_out, ExcCode_out);
    end
    op(6'h23, 32'h0, 32'h0);
    checks++;
    if (DR !== 32'h0) begin
      errors++; $display("FAIL oor_nowrap got %h want 0", DR);
    end
    op(6'h2B, 32'h10, 32'h01020304);
    op(6'h28, 32'h10, 32'h000000AA);
    checks++;
    if (ExcCode_out !== (SUBWORD ? 5'd0 : 5'd10) || exception_out !== !SUBWORD) begin
      errors++; $display("FAIL sb_gate got code=%0d exc=%b want code=%0d exc=%b",
                         ExcCode_out, exception_out, SUBWORD ? 0 : 10, !SUBWORD);
    end
    op(6'h23, 32'h10, 32'h0);
    checks++;
    if (DR !== (SUBWORD ? 32'h010203AA : 32'h01020304)) begin
      errors++; $display("FAIL sb_gate_mem got %h want %h", DR, SUBWORD ? 32'h010203AA : 32'h01020304);
    end
  endtask

  task automatic test_random;
    logic [5:0]  ops [8];
    logic [5:0]  opc;
    logic [31:0] ao;
    int bad;
    ops = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28};
    bad = 0;
    for (int n = 0; n < 2000; n++) begin
      opc = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      case ($urandom_range(0, 9))
        0:       ao = 32'h3FF0 + 32'($urandom_range(0, 19));
        1:       ao = $urandom;
        default: ao = 32'($urandom_range(0, 127));
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0,
           {opc, 26'($urandom)}, ao, $urandom, $urandom_range(0, 15) == 0,
           $urandom, 5'($urandom), 1'($urandom));
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d] got %h want %h", n, act_v, exp_v);
        bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; Inst = 32'h0; AO = 32'h0; rt = 32'h0;
    exception_in = 1'b0; EPC_in = 32'h0; ExcCode_in = 5'd0; BD_in = 1'b0;
    test_reset();
    test_store_load();
    test_subword();
    test_misaligned();
    test_upstream();
    test_flush_reset();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline MEM stage, directly downstream of the execution stage. Consumes the instruction, ALU result, forwarded `rt` and exception bundle produced by EX. Performs data-memory loads and stores with sub-word alignment, detects address exceptions, and registers everything into the MEM/WB boundary for the writeback stage. Owns the data memory array.

## Interface
- `DEPTH_WORDS`, 4096: data memory size in 32-bit words; must be a power of two.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `Inst`  in  32  instruction from EX.
- `AO`  in  32  EX result; the byte address for loads and stores.
- `rt`  in  32  store data, already forwarded.
- `exception_in`  in  1  upstream exception pending.
- `EPC_in`  in  32  upstream EPC.
- `ExcCode_in`  in  5  upstream exception code.
- `BD_in`  in  1  upstream branch-delay flag.
- `flush`  in  1  exception being taken; squash this stage.
- `Inst_out`  out  32  registered instruction to WB; nop (0) when squashed or excepting.
- `AO_out`  out  32  registered `AO`.
- `DR`  out  32  registered load data, extended.
- `exception_out`  out  1  registered.
- `EPC_out`  out  32  registered.
- `ExcCode_out`  out  5  registered.
- `BD_out`  out  1  registered.

## Operation
- Decode on `Inst[31:26]`: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28. All other opcodes are non-memory and pass through.
- Word index = `AO[log2(DEPTH_WORDS)+1:2]`. Byte lane = `AO[1:0]`. Lane 0 is bits 7:0 (little-endian).
- Local exception checks run in priority order:
  - Out of range: `AO >= 4*DEPTH_WORDS`.
  - Misaligned: word access with `AO[1:0]!=0`, or half access with `AO[0]!=0`.
  - Either condition raises AdEL (4) for loads and AdES (5) for stores.
- `exception_out = exception_in | local`.
- `ExcCode_out`: equals `ExcCode_in` if `exception_in` is set, else the local code.
- `EPC_out` and `BD_out` pass straight through, registered.
- Store write enable requires all of: a store opcode, `!exception_in`, no local exception, `!flush`, `!reset`.
  - sw writes the full word.
  - sh writes lane pair `AO[1]`.
  - sb writes a single lane.
  - Other bytes are preserved.
- Load data is read combinationally from the array, then extracted by lane:
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw returns the word unchanged.
  - Non-loads give `DR=0`.
- When `exception_out` would be 1, `Inst_out` is forced to 0 so WB does not write back. The exception fields are still registered.
- `flush=1` loads the whole output register with zeros and suppresses the write. `flush` has priority over every other input.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- A store is committed at the same edge its instruction is registered. A load in the next cycle reads the new data; there is no read-after-write hazard inside the block.
- Same-address store then load in consecutive cycles returns the stored value.
- Reset:
  - All outputs become 0.
  - All memory words become 0, in the same cycle.
  - A store presented during reset is discarded.
- Reset or `flush` asserted mid-stream discards only the instruction currently in the stage. Recovery is immediate on the next cycle.
- Address `4*DEPTH_WORDS-4` is a legal sw. `4*DEPTH_WORDS` raises AdES. Index bits never wrap.

## Configuration
- `MEMORY_ACCESS_SUBWORD_EN`
  - Defined: lb, lbu, lh, lhu, sb and sh behave as above.
  - Undefined: only lw and sw access memory. The six sub-word opcodes raise RI (ExcCode 10): no write, `Inst_out=0`, `exception_out=1`, and upstream precedence is unchanged.

## Test plan
- Store then load: sw `AO=0x10`, `rt=0x89ABCDEF`; next cycle lw 0x10 → `DR=0x89ABCDEF`, `Inst_out=lw`.
- Sub-word access: sb `AO=0x11`, `rt=0x000000F0` over word `0x89ABCDEF`; then lw 0x10 → `0x89ABF0EF`; lb 0x11 → `0xFFFFFFF0`; lbu 0x11 → `0x000000F0`; lhu 0x12 → `0x000089AB`.
- Misaligned accesses:
  - lh `AO=0x13` → `exception_out=1`, `ExcCode_out=4`, `Inst_out=0`.
  - sw `AO=0x12` → `ExcCode_out=5` and memory unchanged (a follow-up lw reads the old value).
- Upstream exception precedence: sw with `exception_in=1`, `ExcCode_in=12`, `EPC_in=0x3008`, `BD_in=1` → no write; outputs carry 12, `0x3008`, 1.
- Flush and reset: sw with `flush=1` → no write, all outputs 0. Reset asserted for one cycle after writes → all outputs 0, and lw 0x10 afterwards → `DR=0`.
- Range boundary (`DEPTH_WORDS=4096`): sw 0x3FFC succeeds; sw 0x4000 → AdES. With the macro undefined, sb 0x10 → `ExcCode_out=10` and no write.
